exec_controller: RTL

- Execution sequencer for the single-cycle MIPS core.
- Replaces direct button-to-clock pulsing with one synchronous clock-enable pulse per executed instruction, driven by:
  - single-step, free-run (prescaled) and run-to-breakpoint modes;
  - a controlled, stretched core reset.
- Sits between the debounced board buttons and the core's enable/reset inputs; exports a cycle count and status for the seven-segment display controller.

---
 rtl/exec_pkg.sv | 17 +
 rtl/exec_controller_btn_sync_edge.sv | 37 +++
 rtl/exec_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execution sequencer: state encoding and display width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

  localparam int STATE_W = 3;

  // Encoding is visible on state_o and decoded by the display controller.
  typedef enum logic [STATE_W-1:0] {
    ST_RST_HOLD = 3'd0,
    ST_HALT     = 3'd1,
    ST_STEP     = 3'd2,
    ST_RUN      = 3'd3,
    ST_BREAK    = 3'd4
  } exec_state_t;

endpackage

// File: rtl/exec_controller_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for one debounced board button.
// Latency: evt_o rises 2 clk edges after the pin rises and lasts exactly one clk.
// Backpressure: none; one event per press, consumed or dropped by the caller.
// Ports: clk, reset (async active-low), btn_i (async pin), evt_o (one-clk pulse).
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic evt_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Only the synchronized copies are compared, never the raw pin.
  assign evt_o = sync2_q & ~prev_q;

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer: turns button events into one cpu_en pulse per instruction
// (step / prescaled run / run-to-breakpoint) and a stretched core reset.
// Latency: 2-3 clk from button pin to state change; cpu_en decoded in the issue clk.
// Backpressure: none; coincident events resolve rst > run > step, losers are dropped.
// Ports: clk, reset (async active-low), step_btn/run_btn/rst_btn (async buttons),
//        bp_en/bp_addr/pc (breakpoint compare), cpu_en/cpu_reset (to core),
//        cycle_count/state_o/halted (to display).
module exec_controller
  import exec_pkg::*;
#(
  parameter int PRESCALE   = 25_000_000,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_btn,
  input  logic               run_btn,
  input  logic               rst_btn,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               cpu_en,
  output logic               cpu_reset,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [STATE_W-1:0] state_o,
  output logic               halted
);

  localparam int PW = $clog2(PRESCALE);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic step_evt, run_evt, rst_evt;

  btn_sync_edge u_step_sync (.clk(clk), .reset(reset), .btn_i(step_btn), .evt_o(step_evt));
  btn_sync_edge u_run_sync  (.clk(clk), .reset(reset), .btn_i(run_btn),  .evt_o(run_evt));
  btn_sync_edge u_rst_sync  (.clk(clk), .reset(reset), .btn_i(rst_btn),  .evt_o(rst_evt));

  exec_state_t      state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             skip_bp_q, skip_bp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             halted_q, halted_d;

  logic presc_wrap;
  logic bp_hit;

  // Word compare only; the byte-offset bits never take part.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{pc[1:0], bp_addr[1:0]};

  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    // skip_bp lets the instruction we stopped on execute once after resuming.
    bp_hit     = bp_en && (pc[31:2] == bp_addr[31:2]) && !skip_bp_q;
  end

  // Issue decode: a pending rst (or, in RUN, a run/halt toggle) wins over the issue.
  always_comb begin
    cpu_en = 1'b0;
    if (state_q == ST_STEP && !rst_evt) begin
      cpu_en = 1'b1;
    end else if (state_q == ST_RUN && presc_wrap && !bp_hit && !rst_evt && !run_evt) begin
      cpu_en = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hold_d    = hold_q;
    skip_bp_d = skip_bp_q;
    cnt_d     = cnt_q;

    if (cpu_en && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_RST_HOLD: begin
        cnt_d = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_HALT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_HALT, ST_BREAK: begin
        if (rst_evt) begin
          state_d = ST_RST_HOLD;
        end else if (run_evt) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
          presc_d   = '0;
        end else if (step_evt) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = rst_evt ? ST_RST_HOLD : ST_HALT;
      end
      ST_RUN: begin
        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        if (rst_evt) begin
          state_d = ST_RST_HOLD;
        end else if (run_evt) begin
          state_d = ST_HALT;
        end else if (presc_wrap) begin
          if (bp_hit) begin
            state_d = ST_BREAK;
          end else begin
            skip_bp_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase

    // Entering the hold restarts the stretch and clears the instruction count.
    if (state_d == ST_RST_HOLD && state_q != ST_RST_HOLD) begin
      hold_d = '0;
      cnt_d  = '0;
    end

    cpu_reset_d = (state_d == ST_RST_HOLD);
    halted_d    = (state_d == ST_HALT) || (state_d == ST_BREAK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST_HOLD;
      presc_q     <= '0;
      hold_q      <= '0;
      skip_bp_q   <= 1'b0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      skip_bp_q   <= skip_bp_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      halted_q    <= halted_d;
    end
  end

  assign state_o     = state_q;
  assign cycle_count = cnt_q;
  assign cpu_reset   = cpu_reset_q;
  assign halted      = halted_q;

endmodule
